// File: rtl/reg_pcls.sv
// PCLS register: holds the low byte of the next program counter.
// Captures ADL (jump/branch/vector target) or the fed-back PCL, with ADL taking priority.
module reg_pcls #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PCL_LOAD,
  input  logic             ADL_LOAD,
  input  logic [WIDTH-1:0] PCL_DATA,
  input  logic [WIDTH-1:0] ADL_DATA,
  output logic [WIDTH-1:0] OUT
);

  logic [WIDTH-1:0] pcls_q;
  logic [WIDTH-1:0] pcls_d;

  // A jump target always overrides the sequential PC when both loads are active.
  always_comb begin
    pcls_d = pcls_q;
    if (ADL_LOAD) begin
      pcls_d = ADL_DATA;
    end else if (PCL_LOAD) begin
      pcls_d = PCL_DATA;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pcls_q <= RESET_VALUE;
    end else begin
      pcls_q <= pcls_d;
    end
  end

  assign OUT = pcls_q;

endmodule

// File: tb/tb_reg_pcls.sv
// Bench for reg_pcls: directed scenarios followed by random loads and
// asynchronous resets, checked against a rule-level reference value.
module tb_reg_pcls;

  localparam logic [7:0] RV = 8'h00;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       PCL_LOAD = 1'b0;
  logic       ADL_LOAD = 1'b0;
  logic [7:0] PCL_DATA = 8'h00;
  logic [7:0] ADL_DATA = 8'h00;
  logic [7:0] OUT;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_val;

  reg_pcls #(
    .WIDTH      (8),
    .RESET_VALUE(RV)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .PCL_LOAD(PCL_LOAD),
    .ADL_LOAD(ADL_LOAD),
    .PCL_DATA(PCL_DATA),
    .ADL_DATA(ADL_DATA),
    .OUT     (OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, expv);
    end
  endtask

  // Value the register must hold after an edge, from the selection rules.
  function automatic logic [7:0] ref_next(input logic r, input logic a_ld, input logic p_ld,
                                          input logic [7:0] a, input logic [7:0] p,
                                          input logic [7:0] cur);
    if (r) return RV;
    if (a_ld) return a;
    if (p_ld) return p;
    return cur;
  endfunction

  // Drive one cycle's inputs at the falling edge, check before and after the rising edge.
  task automatic step(input logic r, input logic a_ld, input logic p_ld,
                      input logic [7:0] a, input logic [7:0] p, input string tag);
    @(negedge CLK);
    RST = r;
    ADL_LOAD = a_ld;
    PCL_LOAD = p_ld;
    ADL_DATA = a;
    PCL_DATA = p;
    #1;
    if (r) exp_val = RV;
    check({tag, "_pre"}, OUT, exp_val);
    @(posedge CLK);
    #1;
    exp_val = ref_next(r, a_ld, p_ld, a, p, exp_val);
    check(tag, OUT, exp_val);
  endtask

  initial begin
    // Reset asserted with a load pending: immediate, and held across edges.
    #2;
    ADL_DATA = 8'hAA;
    ADL_LOAD = 1'b1;
    RST = 1'b1;
    #1;
    exp_val = RV;
    check("reset_async", OUT, RV);
    @(posedge CLK); #1;
    check("reset_hold1", OUT, RV);
    @(posedge CLK); #1;
    check("reset_hold2", OUT, RV);

    // Release reset with loads low.
    step(1'b0, 1'b0, 1'b0, 8'hAA, 8'h00, "release");
    step(1'b0, 1'b1, 1'b0, 8'hAA, 8'h00, "adl_load");
    check("adl_value", OUT, 8'hAA);
    step(1'b0, 1'b0, 1'b0, 8'h55, 8'h77, "data_no_load");
    check("data_no_load_value", OUT, 8'hAA);
    step(1'b0, 1'b0, 1'b1, 8'h55, 8'hAB, "pcl_load");
    check("pcl_value", OUT, 8'hAB);
    step(1'b0, 1'b1, 1'b1, 8'h12, 8'h34, "priority");
    check("priority_value", OUT, 8'h12);

    // Continuous PCL load across the byte boundary.
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'hFE, "cont_fe");
    check("cont_fe_value", OUT, 8'hFE);
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, "cont_ff");
    check("cont_ff_value", OUT, 8'hFF);
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, "cont_00");
    check("cont_00_value", OUT, 8'h00);

    // Reset between edges while a load is active.
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'hAB, "pre_mid_reset");
    @(negedge CLK);
    PCL_LOAD = 1'b0;
    #1;
    RST = 1'b1;
    ADL_LOAD = 1'b1;
    ADL_DATA = 8'h99;
    #1;
    exp_val = RV;
    check("mid_reset_async", OUT, RV);
    @(posedge CLK); #1;
    check("mid_reset_load_lost", OUT, RV);
    step(1'b0, 1'b1, 1'b0, 8'hC3, 8'h00, "after_reset_adl");
    check("after_reset_value", OUT, 8'hC3);

    // Random traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           8'($urandom), 8'($urandom), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #100000;
    bad++;
    $display("FAIL timeout observed=stalled expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_pcls.md
# reg_pcls

Program Counter Low Select (PCLS) register for the 6502 CPU core. It holds the low byte of the next program-counter value. On command it captures either the current PCL (the value fed back through the PC incrementer) or the low address bus ADL (jump, branch and vector targets). Its output feeds the PC incrementer and the PCL register, and it sits in the program-counter datapath between the address-low bus and the PCL register.

## Interface
Parameters:
- WIDTH, 8, data width of all data ports and the internal register.
- RESET_VALUE, 8'h00, value loaded into the register by RST.

Ports:
- CLK  input  1  single system clock; all state changes occur on its rising edge, except reset.
- RST  input  1  asynchronous reset, active-high; forces the register to RESET_VALUE.
- PCL_LOAD  input  1  when high at a rising CLK edge, the register captures PCL_DATA.
- ADL_LOAD  input  1  when high at a rising CLK edge, the register captures ADL_DATA.
- PCL_DATA  input  WIDTH  PCL source value, normally the incremented PCL.
- ADL_DATA  input  WIDTH  ADL bus value.
- OUT  output  WIDTH  current register contents, driven directly from the flop with no combinational path from any input.

## Operation
- Single WIDTH-bit register. OUT always equals the register value.
- Next-state priority is evaluated at each rising CLK edge while RST is low:
  - ADL_LOAD=1: register <= ADL_DATA. ADL has priority; a jump target overrides sequential PC.
  - ADL_LOAD=0 and PCL_LOAD=1: register <= PCL_DATA.
  - Both low: hold the current value.
- Simultaneous ADL_LOAD and PCL_LOAD is legal. ADL_DATA is captured and PCL_DATA is ignored.
- No arithmetic is done in this block. Data is captured verbatim, so PCL_DATA=8'hFF stores FF. Wrap and carry are the incrementer's job.
- Changes on the data inputs while both loads are low have no effect on OUT.
- No X is propagated after reset: OUT is RESET_VALUE until the first load.

## Timing
- RST rising asserts OUT=RESET_VALUE immediately, independent of CLK. While RST is high, loads are ignored and OUT stays RESET_VALUE.
- Reset deassertion is synchronous to CLK. The first load is honoured on the first rising edge after RST goes low.
- Load latency is 1 cycle. Data and load are sampled at rising edge N, and OUT shows the new value after edge N (valid throughout cycle N+1).
- Load signals are level-sampled, not edge-detected. Holding a load high for k cycles captures the data input on each of the k edges.
- Back-to-back loads in consecutive cycles are supported with no bubble.
- Reset mid-operation: RST asserted in any cycle, including one with a load active, yields RESET_VALUE. The load is lost.

## Test plan
- Reset: assert RST with ADL_DATA=AA and ADL_LOAD=1 -> OUT=00 immediately, and it stays 00 across clock edges while RST is high.
- ADL load: RST low, ADL_DATA=AA, pulse ADL_LOAD for one cycle -> OUT=AA after that edge. Then change ADL_DATA to 55 with loads low -> OUT stays AA.
- PCL increment feedback: PCL_DATA=OUT+1=AB, pulse PCL_LOAD for one cycle -> OUT=AB after the edge. OUT is unchanged before the edge.
- Priority: ADL_DATA=12, PCL_DATA=34, both loads high for one edge -> OUT=12.
- Continuous load: PCL_LOAD held high while PCL_DATA steps FE, FF, 00 on successive cycles -> OUT follows FE, FF, 00, each one cycle late. There is no carry or wrap side effect.
- Async reset mid-operation: OUT=AB, assert RST between clock edges -> OUT=00 without waiting for an edge. Release RST and pulse ADL_LOAD with ADL_DATA=C3 -> OUT=C3.
